// File: rtl/bpred_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor table update controller:
// FSM encodings, CPHT counter encodings, default sizes and entry packing.
package bpred_update_ctrl_pkg;

    localparam int CPHT_DEPTH_DEF  = 5;
    localparam int QDEPTH_LOG2_DEF = 2;

    // Controller states
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // CPHT chooser counter encoding; the clear value is CPHT_STRONG_LOCAL
    typedef enum logic [1:0] {
        CPHT_STRONG_LOCAL  = 2'b00,
        CPHT_WEAK_LOCAL    = 2'b01,
        CPHT_WEAK_GLOBAL   = 2'b11,
        CPHT_STRONG_GLOBAL = 2'b10
    } cpht_state_e;

    // Queue entry layout is {idx, taken, local_ok, global_ok}; the low
    // three bits are the training flags built here.
    localparam int ENTRY_FLAG_BITS = 3;

    function automatic logic [ENTRY_FLAG_BITS-1:0] pack_flags(
        input logic taken,
        input logic local_pred,
        input logic global_pred
    );
        return {taken, ~(local_pred ^ taken), ~(global_pred ^ taken)};
    endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Small synchronous FIFO holding pending table updates. The head is read
// combinationally so a freshly pushed entry can be written the next cycle.
module bpred_upd_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count_q == DEPTH_LOG2'(0) + (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // A full queue still accepts a push when it is popping in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Schedules every write into the tournament predictor tables: a clearing
// sweep after reset/flush, then in-order retirement of resolved branches
// through a small queue onto the shared table write port.
module bpred_update_ctrl
    import bpred_update_ctrl_pkg::*;
#(
    parameter int CPHT_DEPTH  = CPHT_DEPTH_DEF,
    parameter int QDEPTH_LOG2 = QDEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    input  logic                  branchM,
    input  logic                  actual_takeM,
    input  logic                  localPred_M,
    input  logic                  globalPred_M,
    input  logic                  predM,
    input  logic [31:0]           pcM,
    input  logic                  tbl_ready,
    output logic                  tbl_we,
    output logic                  tbl_clr,
    output logic [CPHT_DEPTH-1:0] tbl_idx,
    output logic                  tbl_taken,
    output logic                  tbl_local_ok,
    output logic                  tbl_global_ok,
    output logic                  stallM,
    output logic                  mispredM,
    output logic                  busy,
    output logic [31:0]           br_cnt,
    output logic [31:0]           mis_cnt
);

    localparam int ENTRY_W = CPHT_DEPTH + ENTRY_FLAG_BITS;

    logic [0:0]            state_q, state_d;
    logic [CPHT_DEPTH-1:0] sweep_q, sweep_d;
    logic [31:0]           br_cnt_q, br_cnt_d;
    logic [31:0]           mis_cnt_q, mis_cnt_d;

    logic                  in_init;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  accept;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  unused_pc_bits;

    // Only the index bits of the PC reach the tables
    assign unused_pc_bits = ^{pcM[31:CPHT_DEPTH+2], pcM[1:0]};

    assign in_init = (state_q == ST_INIT);

    // Write port, stall and accept decisions; everything is quiet under reset
    always_comb begin
        mispredM      = branchM & (predM ^ actual_takeM);
        busy          = rst | in_init;
        tbl_we        = ~rst & (in_init | ~fifo_empty);
        tbl_clr       = ~rst & in_init;
        tbl_idx       = in_init ? sweep_q : head_entry[ENTRY_W-1 -: CPHT_DEPTH];
        tbl_taken     = ~in_init & head_entry[2];
        tbl_local_ok  = ~in_init & head_entry[1];
        tbl_global_ok = ~in_init & head_entry[0];
        fifo_pop      = ~rst & ~in_init & ~fifo_empty & tbl_ready;
        stallM        = ~rst & ~in_init & branchM & fifo_full & ~fifo_pop;
        accept        = ~rst & ~in_init & branchM & ~stallM & ~flush_req;
        push_entry    = {pcM[CPHT_DEPTH+1:2],
                         pack_flags(actual_takeM, localPred_M, globalPred_M)};
    end

    // FSM, sweep index and counters next-state
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (flush_req) begin
            state_d = ST_INIT;
            sweep_d = '0;
        end else if (in_init) begin
            sweep_d = sweep_q + 1'b1;
            if (&sweep_q) state_d = ST_RUN;
        end
        if (accept) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (mispredM) mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            sweep_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;

    bpred_upd_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (QDEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_req),
        .push  (accept),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Directed bench for bpred_update_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later, state advances on the rising edge.
module tb_bpred_update_ctrl;

    logic        clk;
    logic        rst;
    logic        flush_req;
    logic        branchM;
    logic        actual_takeM;
    logic        localPred_M;
    logic        globalPred_M;
    logic        predM;
    logic [31:0] pcM;
    logic        tbl_ready;
    logic        tbl_we;
    logic        tbl_clr;
    logic [4:0]  tbl_idx;
    logic        tbl_taken;
    logic        tbl_local_ok;
    logic        tbl_global_ok;
    logic        stallM;
    logic        mispredM;
    logic        busy;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    int checks   = 0;
    int failures = 0;

    bpred_update_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush_req     (flush_req),
        .branchM       (branchM),
        .actual_takeM  (actual_takeM),
        .localPred_M   (localPred_M),
        .globalPred_M  (globalPred_M),
        .predM         (predM),
        .pcM           (pcM),
        .tbl_ready     (tbl_ready),
        .tbl_we        (tbl_we),
        .tbl_clr       (tbl_clr),
        .tbl_idx       (tbl_idx),
        .tbl_taken     (tbl_taken),
        .tbl_local_ok  (tbl_local_ok),
        .tbl_global_ok (tbl_global_ok),
        .stallM        (stallM),
        .mispredM      (mispredM),
        .busy          (busy),
        .br_cnt        (br_cnt),
        .mis_cnt       (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush_req = 1'b0; branchM = 1'b1; actual_takeM = 1'b1;
        localPred_M = 1'b0; globalPred_M = 1'b0; predM = 1'b0;
        pcM = 32'h0; tbl_ready = 1'b0;

        // Reset cycle: no write, no stall, busy
        @(negedge clk); #1;
        check("rst_we", tbl_we, 0);
        check("rst_stall", stallM, 0);
        check("rst_busy", busy, 1);
        $display("reset cycle: we=%0b stall=%0b busy=%0b", tbl_we, stallM, busy);

        // Initial clearing sweep, with branches offered that must be dropped
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            branchM = (i == 5) || (i == 6) || (i == 31);
            #1;
            check("init_we", tbl_we, 1);
            check("init_clr", tbl_clr, 1);
            check("init_idx", tbl_idx, i);
            check("init_busy", busy, 1);
            if (branchM) check("init_stall", stallM, 0);
            @(negedge clk);
        end
        branchM = 1'b0;
        #1;
        check("run_busy", busy, 0);
        check("run_we_empty", tbl_we, 0);
        check("init_br_cnt", br_cnt, 0);
        check("init_mis_cnt", mis_cnt, 0);
        $display("sweep done: busy=%0b br_cnt=%0d", busy, br_cnt);

        // Single branch into an empty queue
        @(negedge clk);
        branchM = 1'b1; pcM = 32'h0000_0044; actual_takeM = 1'b1;
        localPred_M = 1'b1; globalPred_M = 1'b0; predM = 1'b1;
        #1;
        check("t2_stall", stallM, 0);
        check("t2_mispred", mispredM, 0);
        @(negedge clk);
        branchM = 1'b0; tbl_ready = 1'b1;
        #1;
        check("t2_we", tbl_we, 1);
        check("t2_clr", tbl_clr, 0);
        check("t2_idx", tbl_idx, 17);
        check("t2_taken", tbl_taken, 1);
        check("t2_local_ok", tbl_local_ok, 1);
        check("t2_global_ok", tbl_global_ok, 0);
        check("t2_br_cnt", br_cnt, 1);
        $display("write idx=%0d taken=%0b lok=%0b gok=%0b", tbl_idx, tbl_taken, tbl_local_ok, tbl_global_ok);
        @(negedge clk); #1;
        check("t2_we_after", tbl_we, 0);

        // Fill the queue with the table side stalled
        @(negedge clk);
        tbl_ready = 1'b0; localPred_M = 1'b1; globalPred_M = 1'b1;
        for (int k = 0; k < 5; k++) begin
            branchM = 1'b1; pcM = 32'((k + 1) << 2);
            actual_takeM = k[0]; predM = k[0];
            #1;
            check("t3_stall", stallM, (k == 4) ? 1 : 0);
            $display("push idx=%0d stall=%0b", k + 1, stallM);
            if (k < 4) @(negedge clk);
        end
        @(negedge clk);
        tbl_ready = 1'b1;
        #1;
        check("t3_first_we", tbl_we, 1);
        check("t3_first_idx", tbl_idx, 1);
        check("t3_full_pop_stall", stallM, 0);
        @(negedge clk);
        branchM = 1'b0;
        for (int j = 2; j <= 5; j++) begin
            #1;
            check("t3_we", tbl_we, 1);
            check("t3_idx", tbl_idx, j);
            check("t3_taken", tbl_taken, (j - 1) & 1);
            $display("retire idx=%0d taken=%0b", tbl_idx, tbl_taken);
            @(negedge clk);
        end
        #1;
        check("t3_drained", tbl_we, 0);
        check("t3_br_cnt", br_cnt, 6);
        check("t3_mis_cnt", mis_cnt, 0);

        // Mispredictions on every other branch, queue streaming
        @(negedge clk);
        localPred_M = 1'b0; globalPred_M = 1'b1;
        for (int k = 0; k < 6; k++) begin
            branchM = 1'b1; pcM = 32'((k + 8) << 2);
            actual_takeM = 1'b1; predM = (k % 2 == 0) ? 1'b0 : 1'b1;
            #1;
            check("t4_mispred", mispredM, (k % 2 == 0) ? 1 : 0);
            check("t4_stall", stallM, 0);
            if (k > 0) begin
                check("t4_idx", tbl_idx, k + 7);
                check("t4_local_ok", tbl_local_ok, 0);
            end
            $display("branch idx=%0d mispred=%0b", k + 8, mispredM);
            @(negedge clk);
        end
        branchM = 1'b0;
        #1;
        check("t4_last_idx", tbl_idx, 13);
        @(negedge clk); #1;
        check("t4_drained", tbl_we, 0);
        check("t4_br_cnt", br_cnt, 12);
        check("t4_mis_cnt", mis_cnt, 3);

        // Flush with three entries queued; the sweep restarts and discards them
        @(negedge clk);
        tbl_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            branchM = 1'b1; pcM = 32'((k + 20) << 2);
            actual_takeM = 1'b0; predM = 1'b0;
            #1;
            @(negedge clk);
        end
        flush_req = 1'b1; branchM = 1'b1; pcM = 32'(23 << 2);
        #1;
        check("t5_pre_busy", busy, 0);
        check("t5_pre_idx", tbl_idx, 20);
        @(negedge clk);
        flush_req = 1'b0; branchM = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            flush_req = (i == 10);
            #1;
            check("t5_busy", busy, 1);
            check("t5_clr", tbl_clr, 1);
            check("t5_idx", tbl_idx, i);
            @(negedge clk);
        end
        flush_req = 1'b0;
        $display("flush: sweep restarted, br_cnt=%0d mis_cnt=%0d", br_cnt, mis_cnt);
        for (int i = 0; i < 32; i++) begin
            branchM = (i % 8 == 3);
            predM = 1'b1; actual_takeM = 1'b0;
            #1;
            check("t6_idx", tbl_idx, i);
            check("t6_we", tbl_we, 1);
            if (branchM) check("t6_stall", stallM, 0);
            @(negedge clk);
        end
        branchM = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_we_empty", tbl_we, 0);
        check("t6_br_cnt", br_cnt, 15);
        check("t6_mis_cnt", mis_cnt, 3);
        @(negedge clk); #1;
        check("t6_still_empty", tbl_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
